// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - framed byte-stream image loader that fills instruction memory and releases the core
// Frame: N lo, N hi, 4*N little-endian payload bytes, then an 8-bit payload checksum.
module boot_loader_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_W     = 10,
   parameter int TIMEOUT    = 65535
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [ADDR_W-1:0]     o_imem_addr,
   output logic [DATA_WIDTH-1:0] o_imem_wdata,
   output logic                  o_imem_we,
   output logic                  o_core_en,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [ADDR_W:0]       o_words_loaded
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_CSUM, S_RUN, S_ERR
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [15:0]             r_n;
   logic [7:0]              r_sum;
   logic [1:0]              r_byte;
   logic [ADDR_W-1:0]       r_widx;
   logic [DATA_WIDTH-1:0]   r_word;
   logic [TW-1:0]           r_tmo;
   logic                    r_we;
   logic [ADDR_W-1:0]       r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [ADDR_W:0]         r_words;
   logic                    w_busy;
   logic                    w_accept;
   logic                    w_last_word;
   logic [15:0]             w_n_full;
   logic [DATA_WIDTH-1:0]   w_word_next;

   assign w_busy      = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                        (r_state == S_LOAD) || (r_state == S_CSUM);
   assign w_accept    = w_busy && i_rx_valid;
   assign w_n_full    = {i_rx_data, r_n[7:0]};
   assign w_last_word = ({{(16-ADDR_W){1'b0}}, r_widx} == (r_n - 16'd1));
   assign w_word_next = {i_rx_data, r_word[DATA_WIDTH-1:8]};

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: ;
         S_HDR0: if (w_accept) w_next = S_HDR1;
         S_HDR1: if (w_accept) begin
            if (w_n_full == 16'd0 || w_n_full > 16'(MEM_DEPTH)) w_next = S_ERR;
            else                                                 w_next = S_LOAD;
         end
         S_LOAD: if (w_accept && r_byte == 2'd3 && w_last_word) w_next = S_CSUM;
         S_CSUM: if (w_accept) w_next = (i_rx_data == r_sum) ? S_RUN : S_ERR;
         S_RUN:  ;
         S_ERR:  ;
         default: w_next = S_IDLE;
      endcase
      if (w_busy && !i_rx_valid && r_tmo == TW'(TIMEOUT - 1)) w_next = S_ERR;
      // start overrides everything, including a byte arriving in the same cycle
      if (i_start) w_next = S_HDR0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_n     <= '0;
         r_sum   <= '0;
         r_byte  <= '0;
         r_widx  <= '0;
         r_word  <= '0;
         r_tmo   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_words <= '0;
      end else begin
         r_we <= 1'b0;
         if (!w_busy || w_accept || w_next != r_state) r_tmo <= '0;
         else                                           r_tmo <= r_tmo + TW'(1);
         if (i_start) begin
            r_n     <= '0;
            r_sum   <= '0;
            r_byte  <= '0;
            r_widx  <= '0;
            r_word  <= '0;
            r_words <= '0;
         end else if (w_accept) begin
            case (r_state)
               S_HDR0: r_n[7:0]  <= i_rx_data;
               S_HDR1: r_n[15:8] <= i_rx_data;
               S_LOAD: begin
                  r_sum  <= r_sum + i_rx_data;
                  r_word <= w_word_next;
                  r_byte <= r_byte + 2'd1;
                  if (r_byte == 2'd3) begin
                     r_we    <= 1'b1;
                     r_addr  <= r_widx;
                     r_wdata <= w_word_next;
                     r_words <= r_words + 1'b1;
                     if (!w_last_word) r_widx <= r_widx + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_rx_ready     = w_busy;
   assign o_busy         = w_busy;
   assign o_imem_we      = r_we;
   assign o_imem_addr    = r_addr;
   assign o_imem_wdata   = r_wdata;
   assign o_words_loaded = r_words;
   assign o_core_en      = (r_state == S_RUN);
   assign o_done         = (r_state == S_RUN);
   assign o_error        = (r_state == S_ERR);

endmodule
